riscv_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decoder; produces the instruction word and its PC consumed by decode. It owns the PC register and issues sequential word reads to a fixed-latency instruction BRAM. Responses are buffered in a small FIFO with valid/ready to decode. A redirect from execute (branch/jump target) squashes all in-flight and buffered fetches.

---
 rtl/riscv_fetch.sv | 127 ++++++++++++
 tb/tb_riscv_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
// riscv_fetch: PC register, fixed-latency imem reads, show-ahead instruction buffer.
// Ports: clk_in/rst_in (async active-low); imem_req_out/imem_addr_out/imem_data_in
//        (BRAM read port); redirect_valid_in/redirect_pc_in (restart fetch);
//        inst_valid_out/inst_ready_in/inst_out/pc_out (valid/ready to decode).
module riscv_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          IMEM_LATENCY = 2,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic [31:0] imem_data_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_pc_in,
   output logic        inst_valid_out,
   input  logic        inst_ready_in,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + IMEM_LATENCY + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

   logic [31:0]             fetch_pc;
   logic                    run;
   logic [IMEM_LATENCY-1:0] trk_v;
   logic [31:0]             trk_pc [IMEM_LATENCY];
   fetch_ent_t              fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW-1:0]           head_idx;
   logic [CW-1:0]           fifo_cnt;
   logic [CW-1:0]           trk_cnt;
   logic                    issue;
   logic                    push;
   logic                    pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
      return (p == '0) ? AW'(FIFO_DEPTH - 1) : p - AW'(1);
   endfunction

   always_comb begin
      trk_cnt = '0;
      for (int i = 0; i < IMEM_LATENCY; i++) begin
         trk_cnt = trk_cnt + CW'(trk_v[i]);
      end
   end

   // Counting every slot already promised (in flight or buffered) means
   // a returning response always has room; run holds off the first request
   // until one edge has passed after reset release.
   assign issue = run && !redirect_valid_in &&
                  ((trk_cnt + fifo_cnt) < CW'(FIFO_DEPTH));
   assign push  = trk_v[IMEM_LATENCY-1];
   assign pop   = inst_valid_out && inst_ready_in;

   assign imem_req_out  = issue;
   assign imem_addr_out = issue ? fetch_pc : '0;

   // When empty, point at the most recently consumed slot so the outputs
   // keep their last values instead of exposing older stale entries.
   assign inst_valid_out = (fifo_cnt != '0);
   assign head_idx       = inst_valid_out ? rd_ptr : ptr_dec(rd_ptr);
   assign inst_out       = fifo_mem[head_idx].inst;
   assign pc_out         = fifo_mem[head_idx].pc;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         fetch_pc <= RESET_PC;
         trk_v    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < IMEM_LATENCY; i++) begin
            trk_pc[i] <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else if (redirect_valid_in) begin
         // Squash everything: pending pop and arriving response included.
         fetch_pc <= redirect_pc_in & 32'hFFFF_FFFC;
         trk_v    <= '0;
         wr_ptr   <= rd_ptr;
         fifo_cnt <= '0;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         for (int i = IMEM_LATENCY - 1; i > 0; i--) begin
            trk_v[i]  <= trk_v[i-1];
            trk_pc[i] <= trk_pc[i-1];
         end
         trk_v[0]  <= issue;
         trk_pc[0] <= fetch_pc;
         if (push) begin
            fifo_mem[wr_ptr] <= '{pc: trk_pc[IMEM_LATENCY-1],
                                  inst: imem_data_in};
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: random + directed stimulus for riscv_fetch against a
// transaction-level queue model of requests in flight and buffered words.
module tb_riscv_fetch;

   localparam int          LAT   = 2;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk_in;
   logic        rst_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic [31:0] imem_data_in;
   logic        redirect_valid_in;
   logic [31:0] redirect_pc_in;
   logic        inst_valid_out;
   logic        inst_ready_in;
   logic [31:0] inst_out;
   logic [31:0] pc_out;

   riscv_fetch #(
      .RESET_PC    (RPC),
      .IMEM_LATENCY(LAT),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .imem_req_out     (imem_req_out),
      .imem_addr_out    (imem_addr_out),
      .imem_data_in     (imem_data_in),
      .redirect_valid_in(redirect_valid_in),
      .redirect_pc_in   (redirect_pc_in),
      .inst_valid_out   (inst_valid_out),
      .inst_ready_in    (inst_ready_in),
      .inst_out         (inst_out),
      .pc_out           (pc_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   // Fixed-latency memory: the address sampled at an edge comes back
   // as data LAT cycles after the request cycle.
   logic [31:0] mp [LAT];
   initial for (int i = 0; i < LAT; i++) mp[i] = '0;
   always @(posedge clk_in) begin
      mp[0] <= imem_addr_out;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
   end
   assign imem_data_in = word(mp[LAT-1]);

   typedef struct {
      logic [31:0] pc;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] bq[$];
   logic [31:0] mpc;
   logic        run_m;
   int          cyc;
   int          checks;
   int          errors;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rdy, input logic rd,
                       input logic [31:0] tgt);
      logic  exp_req;
      logic  exp_v;
      mreq_t t;
      @(negedge clk_in);
      inst_ready_in     = rdy;
      redirect_valid_in = rd;
      redirect_pc_in    = tgt;
      #1;
      exp_v = (bq.size() != 0);
      chk("valid", 32'(inst_valid_out), 32'(exp_v));
      if (exp_v) begin
         chk("pc", pc_out, bq[0]);
         chk("inst", inst_out, word(bq[0]));
      end
      exp_req = run_m && !rd && ((mq.size() + bq.size()) < DEPTH);
      chk("req", 32'(imem_req_out), 32'(exp_req));
      if (exp_req) chk("addr", imem_addr_out, mpc);
      if (rd) begin
         bq.delete();
         mq.delete();
         mpc = tgt & 32'hFFFF_FFFC;
      end else begin
         if (exp_v && rdy) void'(bq.pop_front());
         if (mq.size() != 0 && mq[0].due == cyc) begin
            t = mq.pop_front();
            bq.push_back(t.pc);
         end
         if (exp_req) begin
            mq.push_back('{pc: mpc, due: cyc + LAT});
            mpc = mpc + 32'd4;
         end
      end
      run_m = 1'b1;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      #3;
      rst_in = 1'b0;
      #1;
      chk("rst_valid", 32'(inst_valid_out), 32'd0);
      chk("rst_req", 32'(imem_req_out), 32'd0);
      chk("rst_addr", imem_addr_out, 32'd0);
      chk("rst_inst", inst_out, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      bq.delete();
      mq.delete();
      mpc   = RPC;
      run_m = 1'b0;
      repeat (2) @(posedge clk_in);
      #2;
      rst_in = 1'b1;
   endtask

   function automatic logic [31:0] rand_tgt();
      case ($urandom_range(0, 3))
         0:       return $urandom();
         1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         default: return 32'($urandom_range(0, 1023));
      endcase
   endfunction

   initial begin
      int n;
      checks            = 0;
      errors            = 0;
      cyc               = 0;
      rst_in            = 1'b0;
      inst_ready_in     = 1'b0;
      redirect_valid_in = 1'b0;
      redirect_pc_in    = '0;
      mpc               = RPC;
      run_m             = 1'b0;

      do_reset();
      // Free-running stream.
      repeat (16) step(1'b1, 1'b0, '0);
      // Backpressure: buffer fills, requests stop, then drains in order.
      repeat (10) step(1'b0, 1'b0, '0);
      chk("bp_full", 32'(bq.size()), 32'(DEPTH));
      repeat (12) step(1'b1, 1'b0, '0);

      // Redirect with two in flight and two buffered.
      do_reset();
      n = 0;
      while (!(mq.size() == 2 && bq.size() == 2) && n < 20) begin
         step(1'b0, 1'b0, '0);
         n++;
      end
      chk("mid_reach", 32'(n < 20), 32'd1);
      step(1'b0, 1'b1, 32'h0000_0100);
      repeat (10) step(1'b1, 1'b0, '0);

      // Redirect on an accepted pop, misaligned target.
      chk("pop_ready", 32'(bq.size() != 0), 32'd1);
      step(1'b1, 1'b1, 32'h0000_0203);
      repeat (10) step(1'b1, 1'b0, '0);

      // Address wrap.
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      repeat (10) step(1'b1, 1'b0, '0);

      // Back-to-back redirects.
      step(1'b1, 1'b1, 32'h0000_0400);
      step(1'b1, 1'b1, 32'h0000_0800);
      repeat (8) step(1'b1, 1'b0, '0);

      // Reset with requests outstanding.
      repeat (3) step(1'b0, 1'b0, '0);
      do_reset();
      repeat (10) step(1'b1, 1'b0, '0);

      // Random traffic with occasional mid-stream resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
              rand_tgt());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
